// File: rtl/muldiv_pkg.sv
// Shared definitions for the RISC-V M-extension multiply/divide unit.
package muldiv_pkg;

  // M-extension operation encoded by funct3.
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // Sequencer state encoding.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CALC = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/muldiv_decode.sv
// Combinational decode of an R-type instruction into muldiv controls.
module muldiv_decode
  import muldiv_pkg::*;
(
  input  logic [31:0] instr,
  output muldiv_op_e  op,
  output logic        legal,
  output logic        sign_a,
  output logic        sign_b,
  output logic        is_div,
  output logic        want_hi
);

  // Register-number and rd fields play no part in selecting the operation.
  logic unused_fields;
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  // Classify the instruction and derive operand signedness / result half.
  always_comb begin
    op      = muldiv_op_e'(instr[14:12]);
    legal   = (instr[6:0] == OPCODE_OP) && (instr[31:25] == FUNCT7_MULDIV);
    sign_a  = 1'b0;
    sign_b  = 1'b0;
    is_div  = 1'b0;
    want_hi = 1'b0;
    // For divides, want_hi selects the remainder (upper half of the accumulator).
    case (op)
      OP_MULH:   begin sign_a = 1'b1; sign_b = 1'b1; want_hi = 1'b1; end
      OP_MULHSU: begin sign_a = 1'b1; want_hi = 1'b1; end
      OP_MULHU:  begin want_hi = 1'b1; end
      OP_DIV:    begin sign_a = 1'b1; sign_b = 1'b1; is_div = 1'b1; end
      OP_DIVU:   begin is_div = 1'b1; end
      OP_REM:    begin sign_a = 1'b1; sign_b = 1'b1; is_div = 1'b1; want_hi = 1'b1; end
      OP_REMU:   begin is_div = 1'b1; want_hi = 1'b1; end
      default:   ;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension unit: shift-add multiply, restoring divide,
// one bit per cycle on operand magnitudes with sign fix-up at completion.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int EARLY_OUT = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  localparam int              CNT_W     = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0] MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] cond_neg_x(input logic neg, input logic [XLEN-1:0] v);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cond_neg_2x(input logic neg, input logic [2*XLEN-1:0] v);
    return neg ? -v : v;
  endfunction

  muldiv_op_e dec_op;
  logic       dec_legal, dec_sign_a, dec_sign_b, dec_is_div, dec_want_hi;

  muldiv_decode u_decode (
    .instr   (instr),
    .op      (dec_op),
    .legal   (dec_legal),
    .sign_a  (dec_sign_a),
    .sign_b  (dec_sign_b),
    .is_div  (dec_is_div),
    .want_hi (dec_want_hi)
  );

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic                illegal_q, illegal_d;
  logic [XLEN-1:0]     opd_q, opd_d;
  logic                a_neg_q, a_neg_d, b_neg_q, b_neg_d;
  logic                is_div_q, is_div_d, want_hi_q, want_hi_d, dz_q, dz_d;

  logic                a_neg, b_neg, div_zero, sgn_ovf, early, is_rem;
  logic [XLEN-1:0]     a_mag, b_mag, early_res;
  logic [XLEN:0]       mul_sum, rem_sh, div_diff;
  logic [2*XLEN-1:0]   mul_next, div_next, iter_next, fin_p;
  logic [XLEN-1:0]     fin_q, fin_r, final_res;

  // Operand magnitudes and the special divide cases that can finish at once.
  always_comb begin
    a_neg    = dec_sign_a & rs1[XLEN-1];
    b_neg    = dec_sign_b & rs2[XLEN-1];
    a_mag    = cond_neg_x(a_neg, rs1);
    b_mag    = cond_neg_x(b_neg, rs2);
    div_zero = (rs2 == '0);
    sgn_ovf  = dec_sign_a & dec_sign_b & (rs1 == MOST_NEG) & (rs2 == '1);
    early    = (EARLY_OUT != 0) && dec_is_div && (div_zero || sgn_ovf);
    is_rem   = (dec_op == OP_REM) || (dec_op == OP_REMU);
    if (div_zero) early_res = is_rem ? rs1 : '1;
    else          early_res = is_rem ? '0 : rs1;
  end

  // One multiply or divide step, plus the sign-corrected result of that step.
  always_comb begin
    // Multiply: acc = {partial, multiplier}; add multiplicand on LSB, shift right.
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opd_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    // Divide: acc = {remainder, dividend/quotient}; shift left, trial subtract.
    rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff = rem_sh - {1'b0, opd_q};
    if (rem_sh >= {1'b0, opd_q}) div_next = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    else                         div_next = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    iter_next = is_div_q ? div_next : mul_next;
    // Quotient truncates toward zero; remainder follows the dividend's sign.
    fin_q = dz_q ? '1 : cond_neg_x(a_neg_q ^ b_neg_q, iter_next[XLEN-1:0]);
    fin_r = cond_neg_x(a_neg_q, iter_next[2*XLEN-1:XLEN]);
    fin_p = cond_neg_2x(a_neg_q ^ b_neg_q, iter_next);
    if (is_div_q) final_res = want_hi_q ? fin_r : fin_q;
    else          final_res = want_hi_q ? fin_p[2*XLEN-1:XLEN] : fin_p[XLEN-1:0];
  end

  // Sequencer: IDLE -> CALC (XLEN steps) -> DONE, with flush overriding all.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    result_d  = result_q;
    illegal_d = 1'b0;
    opd_d     = opd_q;
    a_neg_d   = a_neg_q;
    b_neg_d   = b_neg_q;
    is_div_d  = is_div_q;
    want_hi_d = want_hi_q;
    dz_d      = dz_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (!dec_legal) begin
              illegal_d = 1'b1;
            end else if (early) begin
              state_d  = ST_DONE;
              result_d = early_res;
            end else begin
              state_d   = ST_CALC;
              cnt_d     = '0;
              acc_d     = {{XLEN{1'b0}}, (dec_is_div ? a_mag : b_mag)};
              opd_d     = dec_is_div ? b_mag : a_mag;
              a_neg_d   = a_neg;
              b_neg_d   = b_neg;
              is_div_d  = dec_is_div;
              want_hi_d = dec_want_hi;
              dz_d      = div_zero;
            end
          end
        end
        ST_CALC: begin
          acc_d = iter_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_ITER) begin
            state_d  = ST_DONE;
            result_d = final_res;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Control and architectural state, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
    end
  end

  // Operand latches; only meaningful while an op is in flight.
  always_ff @(posedge clk) begin
    opd_q     <= opd_d;
    a_neg_q   <= a_neg_d;
    b_neg_q   <= b_neg_d;
    is_div_q  <= is_div_d;
    want_hi_q <= want_hi_d;
    dz_q      <= dz_d;
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);
  assign result  = result_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit (XLEN=32, EARLY_OUT=1).
module tb_muldiv_unit;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            flush = 1'b0;
  logic [31:0]     instr = '0;
  logic [XLEN-1:0] rs1 = '0;
  logic [XLEN-1:0] rs2 = '0;
  logic            busy, done, illegal;
  logic [XLEN-1:0] result;

  muldiv_unit #(.XLEN(XLEN), .EARLY_OUT(1)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .instr   (instr),
    .rs1     (rs1),
    .rs2     (rs2),
    .flush   (flush),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .illegal (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          t0;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   busy_cnt = 0;
  logic [31:0] last_res;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [2:0] f3);
    return {7'b0000001, 10'd0, f3, 5'd0, 7'b0110011};
  endfunction

  // Independent reference built on 64-bit arithmetic.
  function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sbv, p;
    longint unsigned ua, ub, up;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    p   = 0;
    up  = 0;
    case (f3)
      3'd0: begin p = sa * sbv; return p[31:0]; end
      3'd1: begin p = sa * sbv; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin up = ua * ub; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        p = sa / sbv; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFFFFFF;
        up = ua / ub; return up[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        p = sa % sbv; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        up = ua % ub; return up[31:0];
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && (b == 0)) return 1;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return 33;
  endfunction

  // Completion monitor: every done pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && busy) busy_cnt++;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_done", 64'(1), 64'(0));
      end else begin
        e = sb.pop_front();
        check_eq({e.tag, "_res"}, 64'(result), 64'(e.res));
        check_eq({e.tag, "_lat"}, 64'(cyc - e.t0), 64'(e.lat));
        check_eq({e.tag, "_busy"}, 64'(busy_cnt), 64'(e.lat));
      end
    end
  end

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input string tag);
    exp_t e;
    @(negedge clk);
    instr = mk(f3); rs1 = a; rs2 = b; start = 1'b1;
    busy_cnt = 0;
    e.res = exp; e.lat = lat; e.t0 = cyc; e.tag = tag;
    sb.push_back(e);
    last_res = exp;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      check_eq("timeout", 64'(sb.size()), 64'(0));
      sb.delete();
    end
  endtask

  task automatic run(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input int lat, input string tag);
    issue(f3, a, b, exp, lat, tag);
    wait_idle();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b;
    exp_t        e;

    // Reset state
    #12;
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_done", 64'(done), 64'(0));
    check_eq("rst_result", 64'(result), 64'(0));
    check_eq("rst_illegal", 64'(illegal), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Directed multiplies
    run(3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, "mul");
    run(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 33, "mulh");
    run(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, "mulhu");
    run(3'd2, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 33, "mulhsu");

    // Directed divides
    run(3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, "div");
    run(3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, "rem");
    run(3'd5, 32'd100, 32'd7, 32'd14, 33, "divu");
    run(3'd7, 32'd100, 32'd7, 32'd2, 33, "remu");

    // Divide-by-zero and signed overflow take the early exit
    run(3'd5, 32'd5, 32'd0, 32'hFFFFFFFF, 1, "divu_zero");
    run(3'd6, 32'd5, 32'd0, 32'd5, 1, "rem_zero");
    run(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, "div_ovf");
    run(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1, "rem_ovf");

    // Result holds between operations
    repeat (3) @(negedge clk);
    check_eq("result_hold", 64'(result), 64'(last_res));

    // Randomised ops against the reference model
    for (int i = 0; i < 20; i++) begin
      f3 = 3'($urandom_range(7));
      a  = (i % 7 == 3) ? 32'h80000000 : $urandom;
      case (i % 5)
        0: b = 32'd0;
        1: b = 32'hFFFFFFFF;
        2: b = 32'($urandom_range(1, 17));
        default: b = $urandom;
      endcase
      run(f3, a, b, ref_op(f3, a, b), ref_lat(f3, a, b), "rand");
    end

    // Flush at cycle 10 of a DIV, then a new op started in cycle 11
    @(negedge clk);
    instr = mk(3'd4); rs1 = 32'd1000; rs2 = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_eq("flush_busy", 64'(busy), 64'(0));
    check_eq("flush_done", 64'(done), 64'(0));
    instr = mk(3'd5); rs1 = 32'd1000; rs2 = 32'd3; start = 1'b1;
    busy_cnt = 0;
    e.res = 32'd333; e.lat = 33; e.t0 = cyc; e.tag = "after_flush";
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Illegal instruction (ADD)
    @(negedge clk);
    instr = 32'h00000033; rs1 = 32'd1; rs2 = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("illegal_pulse", 64'(illegal), 64'(1));
    check_eq("illegal_busy", 64'(busy), 64'(0));
    @(negedge clk);
    check_eq("illegal_clear", 64'(illegal), 64'(0));
    check_eq("illegal_busy2", 64'(busy), 64'(0));

    // Start while busy is ignored: exactly one done
    issue(3'd0, 32'd3, 32'd5, 32'd15, 33, "busy_start");
    repeat (2) @(negedge clk);
    instr = mk(3'd5); rs1 = 32'd9; rs2 = 32'd0; start = 1'b1;
    repeat (4) @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (40) @(negedge clk);

    // Asynchronous reset mid-multiply
    issue(3'd0, 32'd11, 32'd13, 32'd143, 33, "reset_mid");
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("areset_busy", 64'(busy), 64'(0));
    check_eq("areset_done", 64'(done), 64'(0));
    check_eq("areset_result", 64'(result), 64'(0));
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run(3'd7, 32'd55, 32'd10, 32'd5, 33, "post_reset");

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
